// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/redirect controls out.
// The slave modport is the controller; the master modport is the pipeline side.
// Optional HAZARD_PERF_COUNTERS_EN adds three 32-bit event counters.
interface pipeline_hazard_controller_if;
  // Pipeline status
  logic [3:0]  rs1_ID;
  logic [3:0]  rs2_ID;
  logic        rs1_used_ID;
  logic        rs2_used_ID;
  logic [3:0]  rd_EX;
  logic        mem_read_EX;
  logic        invalid_EX;
  logic        branch_taken_EX;
  logic [31:0] branch_target_EX;
  logic        dmem_req_MEM;
  logic        dmem_ready_MEM;
  // Controls
  logic        stall_front;
  logic        stall_back;
  logic        flush_IF_ID;
  logic        bubble_ID_EX;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_timeout;
  logic        busy;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] load_use_cnt;
  logic [31:0] mem_stall_cnt;
  logic [31:0] redirect_cnt;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_read_EX, invalid_EX,
           branch_taken_EX, branch_target_EX, dmem_req_MEM, dmem_ready_MEM,
    input  stall_front, stall_back, flush_IF_ID, bubble_ID_EX, redirect_valid, redirect_pc,
           mem_timeout, busy, load_use_cnt, mem_stall_cnt, redirect_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_read_EX, invalid_EX,
           branch_taken_EX, branch_target_EX, dmem_req_MEM, dmem_ready_MEM,
    output stall_front, stall_back, flush_IF_ID, bubble_ID_EX, redirect_valid, redirect_pc,
           mem_timeout, busy, load_use_cnt, mem_stall_cnt, redirect_cnt
  );
`else
  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_read_EX, invalid_EX,
           branch_taken_EX, branch_target_EX, dmem_req_MEM, dmem_ready_MEM,
    input  stall_front, stall_back, flush_IF_ID, bubble_ID_EX, redirect_valid, redirect_pc,
           mem_timeout, busy
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_read_EX, invalid_EX,
           branch_taken_EX, branch_target_EX, dmem_req_MEM, dmem_ready_MEM,
    output stall_front, stall_back, flush_IF_ID, bubble_ID_EX, redirect_valid, redirect_pc,
           mem_timeout, busy
  );
`endif
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage RV32E pipeline.
// FSM INIT -> RUN <-> MEM_WAIT with one shared cycle counter (startup length / wait length).
// Outputs are combinational from state + inputs.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN (saturating load-use/mem-stall/redirect
// event counters).
module pipeline_hazard_controller #(
  parameter int unsigned STARTUP_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT    = 255
) (
  input logic                         clk,
  input logic                         rst_n,
  pipeline_hazard_controller_if.slave hz
);

  localparam int unsigned CntMax = (STARTUP_CYCLES > MEM_TIMEOUT) ? STARTUP_CYCLES : MEM_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] StartLast  = CntW'(STARTUP_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] CntSat     = {CntW{1'b1}};

  typedef enum logic [1:0] {StInit, StRun, StMemWait} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_nxt;

  logic w_load_use;
  logic w_branch;
  logic w_mem_stall;
  logic w_mem_done;
  logic w_timeout_hit;
  logic w_issue;
  logic w_stall_front;
  logic w_stall_back;
  logic w_flush;
  logic w_bubble;
  logic w_redirect;
  logic w_timeout;

  // Hazard conditions decoded from pipeline status.
  always_comb begin
    w_load_use = hz.mem_read_EX && !hz.invalid_EX && (hz.rd_EX != 4'd0) &&
                 ((hz.rs1_used_ID && (hz.rs1_ID == hz.rd_EX)) ||
                  (hz.rs2_used_ID && (hz.rs2_ID == hz.rd_EX)));
    w_branch      = hz.branch_taken_EX && !hz.invalid_EX;
    w_mem_stall   = hz.dmem_req_MEM && !hz.dmem_ready_MEM;
    // A withdrawn request ends the wait just like a ready.
    w_mem_done    = hz.dmem_ready_MEM || !hz.dmem_req_MEM;
    w_timeout_hit = (MEM_TIMEOUT != 0) && (r_cnt == TimeoutVal);
  end

  // Next-state, counter and control outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_issue       = 1'b0;
    w_stall_front = 1'b0;
    w_stall_back  = 1'b0;
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    w_redirect    = 1'b0;
    w_timeout     = 1'b0;

    case (r_state)
      StInit: begin
        w_stall_front = 1'b1;
        w_flush       = 1'b1;
        w_bubble      = 1'b1;
        if (r_cnt == StartLast) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      StRun: begin
        if (w_mem_stall) begin
          w_stall_front = 1'b1;
          w_stall_back  = 1'b1;
          w_state_nxt   = StMemWait;
          w_cnt_nxt     = CntOne;
        end else begin
          w_issue = 1'b1;
        end
      end
      StMemWait: begin
        if (w_mem_done) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
          w_issue     = 1'b1;
        end else if (w_timeout_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
          w_issue     = 1'b1;
        end else begin
          w_stall_front = 1'b1;
          w_stall_back  = 1'b1;
          if (r_cnt != CntSat) begin
            w_cnt_nxt = r_cnt + CntOne;
          end
        end
      end
      default: begin
        w_state_nxt = StInit;
        w_cnt_nxt   = '0;
      end
    endcase

    // First non-stalled cycle: a held branch redirects here, so it is never lost.
    if (w_issue) begin
      if (w_branch) begin
        w_redirect = 1'b1;
        w_flush    = 1'b1;
        w_bubble   = 1'b1;
      end else if (w_load_use) begin
        w_stall_front = 1'b1;
        w_bubble      = 1'b1;
      end
    end
  end

  // State and counter registers; reset forces INIT at once, even mid-wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign hz.stall_front    = w_stall_front;
  assign hz.stall_back     = w_stall_back;
  assign hz.flush_IF_ID    = w_flush;
  assign hz.bubble_ID_EX   = w_bubble;
  assign hz.redirect_valid = w_redirect;
  assign hz.redirect_pc    = w_redirect ? hz.branch_target_EX : 32'd0;
  assign hz.mem_timeout    = w_timeout;
  assign hz.busy           = (r_state != StRun);

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] r_lu_cnt;
  logic [31:0] r_ms_cnt;
  logic [31:0] r_rd_cnt;
  logic        w_lu_fire;

  // A bubble without a flush only happens on a load-use stall.
  assign w_lu_fire = w_bubble && !w_flush;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt <= 32'd0;
      r_ms_cnt <= 32'd0;
      r_rd_cnt <= 32'd0;
    end else begin
      if (w_lu_fire && (r_lu_cnt != 32'hFFFF_FFFF)) r_lu_cnt <= r_lu_cnt + 32'd1;
      if (w_stall_back && (r_ms_cnt != 32'hFFFF_FFFF)) r_ms_cnt <= r_ms_cnt + 32'd1;
      if (w_redirect && (r_rd_cnt != 32'hFFFF_FFFF)) r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign hz.load_use_cnt  = r_lu_cnt;
  assign hz.mem_stall_cnt = r_ms_cnt;
  assign hz.redirect_cnt  = r_rd_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

  localparam int S  = 4;
  localparam int MT = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(
    .STARTUP_CYCLES(S),
    .MEM_TIMEOUT   (MT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: startup edges still owed, and index of the current memory-wait cycle.
  int startup_left = S;
  int wait_n       = 0;
  int nx_startup;
  int nx_wait;

  logic        e_sf, e_sb, e_fl, e_bu, e_rv, e_to, e_busy;
  logic [31:0] e_pc;
  logic        m_stalled, m_done, m_to, m_lu;
  logic [38:0] exp_v, got_v;

  // Model + per-cycle compare: inputs change at negedge, compare 2ns later, commit at posedge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      {e_sf, e_sb, e_fl, e_bu, e_rv, e_to, e_busy} = '0;
      e_pc = 32'd0;
      if (!rst_n || startup_left > 0) begin
        {e_sf, e_fl, e_bu, e_busy} = 4'b1111;
        nx_startup = !rst_n ? S : startup_left - 1;
        nx_wait    = 0;
      end else begin
        nx_startup = 0;
        e_busy     = (wait_n > 0);
        m_to       = 1'b0;
        if (wait_n == 0) begin
          m_stalled = hz.dmem_req_MEM && !hz.dmem_ready_MEM;
        end else begin
          m_done    = hz.dmem_ready_MEM || !hz.dmem_req_MEM;
          m_to      = !m_done && (wait_n == MT);
          m_stalled = !m_done && !m_to;
        end
        m_lu = hz.mem_read_EX && !hz.invalid_EX && (hz.rd_EX != 0) &&
               ((hz.rs1_used_ID && hz.rs1_ID == hz.rd_EX) ||
                (hz.rs2_used_ID && hz.rs2_ID == hz.rd_EX));
        if (m_stalled) begin
          e_sf    = 1'b1;
          e_sb    = 1'b1;
          nx_wait = wait_n + 1;
        end else begin
          e_to    = m_to;
          nx_wait = 0;
          if (hz.branch_taken_EX && !hz.invalid_EX) begin
            e_rv = 1'b1;
            e_pc = hz.branch_target_EX;
            e_fl = 1'b1;
            e_bu = 1'b1;
          end else if (m_lu) begin
            e_sf = 1'b1;
            e_bu = 1'b1;
          end
        end
      end
      exp_v = {e_sf, e_sb, e_fl, e_bu, e_rv, e_pc, e_to, e_busy};
      got_v = {hz.stall_front, hz.stall_back, hz.flush_IF_ID, hz.bubble_ID_EX,
               hz.redirect_valid, hz.redirect_pc, hz.mem_timeout, hz.busy};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h (sf,sb,fl,bu,rv,pc,to,busy)",
                 $time, got_v, exp_v);
      end
      @(posedge clk);
      startup_left = nx_startup;
      wait_n       = nx_wait;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  task automatic clr();
    hz.rs1_ID           = 4'd0;
    hz.rs2_ID           = 4'd0;
    hz.rs1_used_ID      = 1'b0;
    hz.rs2_used_ID      = 1'b0;
    hz.rd_EX            = 4'd0;
    hz.mem_read_EX      = 1'b0;
    hz.invalid_EX       = 1'b0;
    hz.branch_taken_EX  = 1'b0;
    hz.branch_target_EX = 32'd0;
    hz.dmem_req_MEM     = 1'b0;
    hz.dmem_ready_MEM   = 1'b0;
  endtask

  initial begin
    clr();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Startup: four INIT cycles after release, then RUN.
    @(negedge clk);
    rst_n = 1'b1;
    #3 chk("init_c1", {hz.flush_IF_ID, hz.bubble_ID_EX, hz.busy}, 3'b111);
    for (int i = 2; i <= S; i++) begin
      @(negedge clk);
      #3 chk("init_cn", {hz.flush_IF_ID, hz.bubble_ID_EX, hz.busy}, 3'b111);
    end
    @(negedge clk);
    #3 chk("run_busy", hz.busy, 0);

    // Load-use: one-cycle bubble, clears once the bubble reaches EX.
    @(negedge clk);
    hz.mem_read_EX = 1'b1; hz.rd_EX = 4'd5; hz.rs1_ID = 4'd5; hz.rs1_used_ID = 1'b1;
    #3 chk("lu_stall", {hz.stall_front, hz.bubble_ID_EX, hz.stall_back}, 3'b110);
    @(negedge clk);
    hz.invalid_EX = 1'b1;
    #3 chk("lu_clear", {hz.stall_front, hz.bubble_ID_EX}, 2'b00);

    // x0 never hazards.
    @(negedge clk);
    clr();
    hz.mem_read_EX = 1'b1; hz.rd_EX = 4'd0; hz.rs1_ID = 4'd0; hz.rs1_used_ID = 1'b1;
    #3 chk("x0_nohaz", {hz.stall_front, hz.bubble_ID_EX}, 2'b00);

    // Taken branch.
    @(negedge clk);
    clr();
    hz.branch_taken_EX = 1'b1; hz.branch_target_EX = 32'h100;
    #3 chk("br_valid", hz.redirect_valid, 1);
    chk("br_pc", hz.redirect_pc, 32'h100);
    chk("br_flush", {hz.flush_IF_ID, hz.bubble_ID_EX, hz.stall_front}, 3'b110);
    @(negedge clk);
    clr();
    #3 chk("br_idle", hz.redirect_valid, 0);

    // Memory wait with a branch held in EX.
    @(negedge clk);
    hz.dmem_req_MEM = 1'b1; hz.branch_taken_EX = 1'b1; hz.branch_target_EX = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #3 chk("mw_stall", {hz.stall_front, hz.stall_back, hz.redirect_valid}, 3'b110);
      @(negedge clk);
    end
    hz.dmem_ready_MEM = 1'b1;
    #3 chk("mw_ready_rv", {hz.redirect_valid, hz.stall_front, hz.stall_back}, 3'b100);
    chk("mw_ready_pc", hz.redirect_pc, 32'h200);

    // Timeout after MT wait cycles.
    @(negedge clk);
    clr();
    hz.dmem_req_MEM = 1'b1;
    #3 chk("to_detect", hz.stall_back, 1);
    for (int k = 1; k <= MT; k++) begin
      @(negedge clk);
      #3 chk("to_pulse", hz.mem_timeout, (k == MT) ? 1 : 0);
    end
    chk("to_nostall", hz.stall_back, 0);
    @(negedge clk);
    hz.dmem_req_MEM = 1'b0;
    #3 chk("to_after", {hz.busy, hz.mem_timeout}, 2'b00);

    // Reset in the middle of a wait.
    @(negedge clk);
    hz.dmem_req_MEM = 1'b1;
    repeat (2) @(negedge clk);
    #3 chk("mid_busy", hz.busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #3 chk("mid_rst", {hz.busy, hz.stall_back, hz.flush_IF_ID}, 3'b101);
    @(negedge clk);
    clr();
    rst_n = 1'b1;
    repeat (S + 1) @(negedge clk);

    // Randomized traffic; small register indices make hazards frequent.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      hz.rs1_ID           = 4'($urandom_range(0, 3));
      hz.rs2_ID           = 4'($urandom_range(0, 3));
      hz.rd_EX            = 4'($urandom_range(0, 3));
      hz.rs1_used_ID      = 1'($urandom_range(0, 1));
      hz.rs2_used_ID      = 1'($urandom_range(0, 1));
      hz.mem_read_EX      = 1'($urandom_range(0, 1));
      hz.invalid_EX       = ($urandom_range(0, 3) == 0);
      hz.branch_taken_EX  = ($urandom_range(0, 4) == 0);
      hz.branch_target_EX = $urandom;
      hz.dmem_req_MEM     = ($urandom_range(0, 9) < 4) || (wait_n > 0 && $urandom_range(0, 9) < 9);
      hz.dmem_ready_MEM   = ($urandom_range(0, 9) < 3);
    end

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
